signed_minmax_tracker: RTL and testbench



---
 rtl/signed_minmax_tracker.sv | 183 ++++++++++++++++++
 tb/tb_signed_minmax_tracker.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_minmax_tracker.sv
// Windowed signed min/max tracker: reports max, min and all-equal once per WINDOW samples.
// Optional MINMAX_IDX_EN adds in-window positions of the first max and first min.
module signed_minmax_tracker #(
  parameter int WIDTH  = 16,
  parameter int WINDOW = 8,
  localparam int CW    = $clog2(WINDOW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic             out_eq
`ifdef MINMAX_IDX_EN
  ,
  output logic [CW-1:0]    out_max_idx,
  output logic [CW-1:0]    out_min_idx
`endif
);

  typedef enum logic [0:0] {FILL = 1'b0, DONE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic             eq_q, eq_d;
`ifdef MINMAX_IDX_EN
  logic [CW-1:0]    max_idx_q, max_idx_d;
  logic [CW-1:0]    min_idx_q, min_idx_d;
`endif

  logic accept_s;
  logic first_s;
  logic last_s;
  logic gt_s;
  logic lt_s;
  logic ne_s;

  assign accept_s = in_valid & in_ready;
  assign first_s  = (cnt_q == {CW{1'b0}});
  assign last_s   = (cnt_q == CW'(WINDOW - 1));

  // Comparator decisions against the running extremes, strictly signed.
  assign gt_s = $signed(in_data) > $signed(max_q);
  assign lt_s = $signed(in_data) < $signed(min_q);
  assign ne_s = (in_data != max_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (accept_s && last_s) begin
          state_d = DONE;
        end else begin
          state_d = FILL;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = FILL;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      FILL: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    max_d = max_q;
    min_d = min_q;
    eq_d  = eq_q;
`ifdef MINMAX_IDX_EN
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
`endif
    if (accept_s) begin
      if (last_s) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (first_s) begin
        max_d = in_data;
        min_d = in_data;
        eq_d  = 1'b1;
`ifdef MINMAX_IDX_EN
        max_idx_d = cnt_q;
        min_idx_d = cnt_q;
`endif
      end else begin
        // Strict compares: ties keep both the value and the earlier index.
        if (gt_s) begin
          max_d = in_data;
`ifdef MINMAX_IDX_EN
          max_idx_d = cnt_q;
`endif
        end else begin
          max_d = max_q;
        end
        if (lt_s) begin
          min_d = in_data;
`ifdef MINMAX_IDX_EN
          min_idx_d = cnt_q;
`endif
        end else begin
          min_d = min_q;
        end
        if (ne_s) begin
          eq_d = 1'b0;
        end else begin
          eq_d = eq_q;
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
      max_q <= {WIDTH{1'b0}};
      min_q <= {WIDTH{1'b0}};
      eq_q  <= 1'b0;
`ifdef MINMAX_IDX_EN
      max_idx_q <= {CW{1'b0}};
      min_idx_q <= {CW{1'b0}};
`endif
    end else begin
      cnt_q <= cnt_d;
      max_q <= max_d;
      min_q <= min_d;
      eq_q  <= eq_d;
`ifdef MINMAX_IDX_EN
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
`endif
    end
  end

  assign out_max = max_q;
  assign out_min = min_q;
  assign out_eq  = eq_q;
`ifdef MINMAX_IDX_EN
  assign out_max_idx = max_idx_q;
  assign out_min_idx = min_idx_q;
`endif

endmodule

// File: tb/tb_signed_minmax_tracker.sv
// Self-checking bench for signed_minmax_tracker (WIDTH=16, WINDOW=8) against a queue-free array model.
module tb_signed_minmax_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_max;
  logic [15:0] out_min;
  logic        out_eq;
`ifdef MINMAX_IDX_EN
  logic [2:0]  out_max_idx;
  logic [2:0]  out_min_idx;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] win [8];
  logic [15:0] exp_max;
  logic [15:0] exp_min;
  logic        exp_eq;
  logic [2:0]  exp_max_idx;
  logic [2:0]  exp_min_idx;

  signed_minmax_tracker #(.WIDTH(16), .WINDOW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_min   (out_min),
    .out_eq    (out_eq)
`ifdef MINMAX_IDX_EN
    ,
    .out_max_idx (out_max_idx),
    .out_min_idx (out_min_idx)
`endif
  );

  always #5 clk = ~clk;

  // Reference: scan the whole window with plain integer arithmetic.
  task automatic model_window();
    int mx;
    int mn;
    int v;
    mx = $signed(win[0]);
    mn = $signed(win[0]);
    exp_eq = 1'b1;
    exp_max_idx = 3'd0;
    exp_min_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      v = $signed(win[i]);
      if (v > mx) begin mx = v; exp_max_idx = 3'(i); end
      if (v < mn) begin mn = v; exp_min_idx = 3'(i); end
      if (win[i] != win[0]) exp_eq = 1'b0;
    end
    exp_max = mx[15:0];
    exp_min = mn[15:0];
  endtask

  task automatic push(input logic [15:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk);
  endtask

  task automatic gap();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    @(posedge clk);
  endtask

  task automatic send_window(input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) gap();
      push(win[i]);
    end
  endtask

  task automatic await_frame(output int lat);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  task automatic accept_frame();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
    #12;
    n_checks++;
    if ({in_ready, out_valid, out_max, out_min, out_eq} !== {1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vld=%b max=%h min=%h eq=%b, required 1 0 0000 0000 0", in_ready, out_valid, out_max, out_min, out_eq);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int lat;
    win = '{16'd3, 16'hFFFF, 16'd7, 16'd0, 16'd7, 16'hFFFB, 16'd2, 16'd1};
    send_window(1'b0);
    await_frame(lat);
    n_checks++;
    if (lat !== 0) begin n_fail++; $display("FAIL directed_latency: %0d extra cycles, required 0", lat); end
    n_checks++;
    if ({out_max, out_min, out_eq} !== {16'd7, 16'hFFFB, 1'b0}) begin
      n_fail++;
      $display("FAIL directed_frame: max=%h min=%h eq=%b, required 0007 fffb 0", out_max, out_min, out_eq);
    end
`ifdef MINMAX_IDX_EN
    n_checks++;
    if ({out_max_idx, out_min_idx} !== {3'd2, 3'd5}) begin
      n_fail++;
      $display("FAIL directed_idx: max_idx=%0d min_idx=%0d, required 2 5", out_max_idx, out_min_idx);
    end
`endif
    accept_frame();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL directed_accept: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_all_min();
    int lat;
    for (int i = 0; i < 8; i++) win[i] = 16'h8000;
    send_window(1'b0);
    await_frame(lat);
    n_checks++;
    if ({out_max, out_min, out_eq} !== {16'h8000, 16'h8000, 1'b1}) begin
      n_fail++;
      $display("FAIL all_min_frame: max=%h min=%h eq=%b, required 8000 8000 1", out_max, out_min, out_eq);
    end
    accept_frame();
  endtask

  task automatic test_alternating();
    int lat;
    for (int i = 0; i < 8; i++) win[i] = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
    send_window(1'b0);
    await_frame(lat);
    n_checks++;
    if ({out_max, out_min, out_eq} !== {16'h7FFF, 16'h8000, 1'b0}) begin
      n_fail++;
      $display("FAIL alternating_frame: max=%h min=%h eq=%b, required 7fff 8000 0", out_max, out_min, out_eq);
    end
    accept_frame();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    for (int i = 0; i < 8; i++) win[i] = 16'(i * 100 + 5);
    model_window();
    send_window(1'b0);
    await_frame(lat);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, out_max, out_min, out_eq} !== {1'b0, 1'b1, exp_max, exp_min, exp_eq}) begin
        n_fail++;
        if (bad == 0) $display("FAIL hold_stable: rdy=%b vld=%b max=%h min=%h, required 0 1 %h %h", in_ready, out_valid, out_max, out_min, exp_max, exp_min);
        bad++;
      end
    end
    accept_frame();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) win[i] = 16'(-200 - i * 3);
    model_window();
    send_window(1'b0);
    await_frame(lat);
    n_checks++;
    if ({out_max, out_min, out_eq} !== {exp_max, exp_min, exp_eq}) begin
      n_fail++;
      $display("FAIL fresh_window: max=%h min=%h eq=%b, required %h %h %b", out_max, out_min, out_eq, exp_max, exp_min, exp_eq);
    end
    accept_frame();
  endtask

  task automatic test_random_gaps();
    int lat;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) win[i] = (r == 5) ? 16'h1234 : 16'($urandom);
      model_window();
      send_window(1'b1);
      await_frame(lat);
      n_checks++;
      if ({out_max, out_min, out_eq} !== {exp_max, exp_min, exp_eq}) begin
        n_fail++;
        $display("FAIL random_gaps_%0d: max=%h min=%h eq=%b, required %h %h %b", r, out_max, out_min, out_eq, exp_max, exp_min, exp_eq);
      end
`ifdef MINMAX_IDX_EN
      n_checks++;
      if ({out_max_idx, out_min_idx} !== {exp_max_idx, exp_min_idx}) begin
        n_fail++;
        $display("FAIL random_idx_%0d: %0d %0d, required %0d %0d", r, out_max_idx, out_min_idx, exp_max_idx, exp_min_idx);
      end
`endif
      accept_frame();
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 8; i++) win[i] = 16'(1000 + i);
      if (phase == 0) begin
        for (int i = 0; i < 5; i++) push(win[i]);
        @(negedge clk);
      end else begin
        send_window(1'b0);
        await_frame(lat);
      end
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, out_valid, out_max, out_min, out_eq} !== {1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_mid_%0d: rdy=%b vld=%b max=%h min=%h eq=%b, required 1 0 0000 0000 0", phase, in_ready, out_valid, out_max, out_min, out_eq);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) win[i] = 16'(50 - i * 20);
      model_window();
      send_window(1'b0);
      await_frame(lat);
      n_checks++;
      if ({out_max, out_min, out_eq} !== {exp_max, exp_min, exp_eq}) begin
        n_fail++;
        $display("FAIL after_reset_%0d: max=%h min=%h eq=%b, required %h %h %b", phase, out_max, out_min, out_eq, exp_max, exp_min, exp_eq);
      end
      accept_frame();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_all_min();
    test_alternating();
    test_backpressure();
    test_random_gaps();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
